// File: rtl/shift_exec_stage_pkg.sv
// Shared ALU definitions: datapath width, shift opcodes and the S1 request bundle.
package shift_exec_stage_pkg;

  localparam int ALU_DATA_W = 32;
  localparam int SHAMT_W    = 5;

  localparam logic [4:0] OP_SLL = 5'b00100;
  localparam logic [4:0] OP_SRA = 5'b00101;

  typedef struct packed {
    logic [4:0]            opcode;
    logic [ALU_DATA_W-1:0] operand;
    logic [SHAMT_W-1:0]    shamt;
  } shift_req_t;

  function automatic logic is_shift_op(input logic [4:0] op);
    return (op == OP_SLL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/left_barrel_shifter.sv
// Log-depth logical left shifter, zero fill; level i shifts by 2**i.
module left_barrel_shifter #(
  parameter int DATA_W = 32,
  parameter int LV     = $clog2(DATA_W)
) (
  input  logic [DATA_W-1:0] data_in,
  input  logic [LV-1:0]     shamt,
  output logic [DATA_W-1:0] data_out
);
  logic [LV:0][DATA_W-1:0] stg;

  assign stg[0] = data_in;

  for (genvar i = 0; i < LV; i++) begin : g_lvl
    localparam int SH = 1 << i;
    assign stg[i+1] = shamt[i] ? {stg[i][DATA_W-1-SH:0], {SH{1'b0}}} : stg[i];
  end

  assign data_out = stg[LV];
endmodule

// File: rtl/right_barrel_shifter.sv
// Log-depth right shifter; arith=1 replicates the sign bit into vacated positions.
module right_barrel_shifter #(
  parameter int DATA_W = 32,
  parameter int LV     = $clog2(DATA_W)
) (
  input  logic [DATA_W-1:0] data_in,
  input  logic [LV-1:0]     shamt,
  input  logic              arith,
  output logic [DATA_W-1:0] data_out
);
  logic [LV:0][DATA_W-1:0] stg;
  logic                    fill;

  assign fill   = arith & data_in[DATA_W-1];
  assign stg[0] = data_in;

  for (genvar i = 0; i < LV; i++) begin : g_lvl
    localparam int SH = 1 << i;
    assign stg[i+1] = shamt[i] ? {{SH{fill}}, stg[i][DATA_W-1:SH]} : stg[i];
  end

  assign data_out = stg[LV];
endmodule

// File: rtl/shift_exec_stage.sv
// Two-stage SLL/SRA execute stage with valid/ready on both sides.
module shift_exec_stage
  import shift_exec_stage_pkg::*;
#(
  parameter int TAG_W  = 5,
  parameter int DATA_W = ALU_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_opcode,
  input  logic [DATA_W-1:0] in_operandA,
  input  logic [4:0]        in_shamt,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_illegal
);
  logic [2:1]        vld_pipe;
  logic              adv;
  shift_req_t        s1_q;
  logic [TAG_W-1:0]  s1_tag;
  logic [DATA_W-1:0] sll_out, sra_out, s2_res;
  logic              s2_ill;

  assign adv       = !vld_pipe[2] || out_ready;
  assign in_ready  = !vld_pipe[1] || !vld_pipe[2] || out_ready;
  assign out_valid = vld_pipe[2];

  // in_ready high implies S1 is empty or draining into S2 this edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_pipe[1] <= 1'b0;
      s1_q        <= '0;
      s1_tag      <= '0;
    end else if (in_ready) begin
      vld_pipe[1] <= in_valid;
      if (in_valid) begin
        s1_q   <= '{opcode: in_opcode, operand: in_operandA, shamt: in_shamt};
        s1_tag <= in_tag;
      end
    end
  end

  left_barrel_shifter #(.DATA_W(DATA_W)) u_sll (
    .data_in (s1_q.operand),
    .shamt   (s1_q.shamt),
    .data_out(sll_out)
  );

  right_barrel_shifter #(.DATA_W(DATA_W)) u_sra (
    .data_in (s1_q.operand),
    .shamt   (s1_q.shamt),
    .arith   (1'b1),
    .data_out(sra_out)
  );

  always_comb begin
    s2_res = '0;
    s2_ill = 1'b0;
    case (s1_q.opcode)
      OP_SLL:  s2_res = sll_out;
      OP_SRA:  s2_res = sra_out;
      default: s2_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_pipe[2] <= 1'b0;
      out_result  <= '0;
      out_tag     <= '0;
      out_illegal <= 1'b0;
    end else if (adv) begin
      vld_pipe[2] <= vld_pipe[1];
      if (vld_pipe[1]) begin
        out_result  <= s2_res;
        out_tag     <= s1_tag;
        out_illegal <= s2_ill;
      end
    end
  end
endmodule

// File: doc/shift_exec_stage.md
SHIFT_EXEC_STAGE -- requirements
Module: shift_exec_stage

Interface
REQ-001 SHALL have parameter TAG_W, default 5, destination-register tag width.
REQ-002 SHALL have parameter DATA_W, default 32, operand/result width; only 32 supported.
REQ-003 SHALL have port clock  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  upstream offers an operation.
REQ-006 SHALL have port in_ready  output  1  stage accepts the operation this cycle.
REQ-007 SHALL have port in_opcode  input  5  ALU opcode; 00100 = SLL, 00101 = SRA.
REQ-008 SHALL have port in_operandA  input  32  value to shift.
REQ-009 SHALL have port in_shamt  input  5  shift amount, 0..31.
REQ-010 SHALL have port in_tag  input  TAG_W  destination tag, passed through unchanged.
REQ-011 SHALL have port out_valid  output  1  result available.
REQ-012 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-013 SHALL have port out_result  output  32  shifted value.
REQ-014 SHALL have port out_tag  output  TAG_W  tag of the result.
REQ-015 SHALL have port out_illegal  output  1  opcode was neither SLL nor SRA.

Function
REQ-016 SHALL be a two-stage pipeline: S1 registers opcode/operand/shamt/tag; S2 registers the shift result, tag and illegal flag.
REQ-017 SHALL give a latency of exactly 2 cycles from an accepted input (in_valid & in_ready) to out_valid, with no stalls.
REQ-018 SHALL sustain throughput of one operation per cycle while out_ready is held high.
REQ-019 SHALL transfer on a handshake only when valid & ready are both high on a rising edge.
REQ-020 SHALL advance S2 when S2 is empty or out_ready = 1, and advance S1 into S2 under the same condition.
REQ-021 SHALL drive in_ready = !v1 | !v2 | out_ready; in_ready SHALL NOT depend on in_valid.
REQ-022 SHALL hold out_result/out_tag/out_illegal stable while out_valid = 1 and out_ready = 0.
REQ-023 SHALL compute SLL as logical left shift with zero fill and SRA as arithmetic right shift replicating bit 31.
REQ-024 SHALL pass operandA unchanged when shamt = 0, for both SLL and SRA.
REQ-025 SHALL, for any other opcode, produce out_result = 0 and out_illegal = 1, consume one slot, and keep the pipeline running.
REQ-026 SHALL drop nothing and duplicate nothing under any out_ready pattern; order SHALL be preserved.
REQ-027 SHALL hold in_ready low when both stages are full and out_ready = 0.

Reset
REQ-028 SHALL clear v1 and v2 immediately on reset low, independent of clock.
REQ-029 SHALL drive out_valid = 0, out_result = 0, out_tag = 0 and out_illegal = 0 during reset.
REQ-030 SHALL discard in-flight operations when reset asserts mid-operation, and SHALL accept input on the first edge after release.

Structure
REQ-031 SHALL take the SLL/SRA opcode constants and DATA_W from a shared ALU package, also used by the ALU decoder.
REQ-032 SHALL instantiate the existing right_barrel_shifter for SRA and one new sub-module, left_barrel_shifter (5-level log shifter, same port shape), for SLL, both fed from S1.
REQ-033 SHALL select between the shifter outputs with opcode-driven muxing ahead of the S2 register; no shifting logic SHALL sit after S2.

Verification
REQ-034 SHALL cover: SRA 0x80000000, shamt 4, tag 3, out_ready = 1 -> two cycles later out_valid = 1, out_result 0xF8000000, out_tag 3.
REQ-035 SHALL cover: SLL 0x00000001, shamt 31 -> 0x80000000; SRA 0x7FFFFFFF, shamt 31 -> 0x00000000; shamt 0 -> operand unchanged.
REQ-036 SHALL cover: out_ready = 0 for 5 cycles with in_valid held high -> exactly 2 accepted, in_ready = 0 from the third cycle; on out_ready = 1, results emerge in order, one per cycle.
REQ-037 SHALL cover: opcode 00000, operand 0x1234 -> out_result 0, out_illegal = 1; the next SLL result has out_illegal = 0.
REQ-038 SHALL cover: reset low while both stages are valid -> out_valid = 0 in the same cycle, no stale result after release.
REQ-039 SHALL cover: a random out_ready stream over 1000 operations -> scoreboard match, including tag order, with zero loss.
